// File: rtl/misr_checker.sv
// MISR response compactor with end-of-run golden-signature comparator.
// Optional idle watchdog enabled by defining MISR_TIMEOUT_EN.
module misr_checker #(
  parameter int             W            = 16,
  parameter logic [W-1:0]   POLY         = 16'h002D,
  parameter logic [W-1:0]   SEED         = '0,
  parameter int             NUM_PATTERNS = 256,
  parameter logic [W-1:0]   GOLDEN       = '0,
  parameter int             TIMEOUT      = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         resp_valid,
  input  logic [W-1:0] resp,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic [W-1:0] signature
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);

  if (W < 2 || NUM_PATTERNS < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("misr_checker: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;

`ifdef MISR_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  // Galois step: shift left, fold the outgoing MSB back through the taps, then mix in the response.
  function automatic logic [W-1:0] misr_next(input logic [W-1:0] s, input logic [W-1:0] r);
    misr_next = {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0) ^ r;
  endfunction

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
`ifdef MISR_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d     = SEED;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_RUN;
`ifdef MISR_TIMEOUT_EN
          idle_d    = '0;
`endif
        end
      end
      S_RUN: begin
        if (resp_valid) begin
          sig_d = misr_next(sig_q, resp);
          cnt_d = cnt_q + CW'(1);
`ifdef MISR_TIMEOUT_EN
          idle_d = '0;
`endif
          if (cnt_q == LAST_CNT) begin
            state_d = S_CHECK;
          end
        end
`ifdef MISR_TIMEOUT_EN
        else begin
          idle_d = idle_q + IW'(1);
          // A valid response wins over the watchdog, so only idle cycles can trip it.
          if (idle_q == IDLE_LAST) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      S_CHECK: begin
        pass_d  = (sig_q == GOLDEN);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sig_q     <= SEED;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef MISR_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
`ifdef MISR_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign signature = sig_q;

endmodule

// File: doc/misr_checker.md
# misr_checker

Multiple-input signature register (MISR) response compactor with a built-in pass/fail comparator. It is the receiving end of the BIST path: the LFSR pattern generator drives stimuli into the circuit under test, and this block folds the circuit's per-cycle responses into a signature. After a programmed number of patterns it compares that signature against a golden value and reports pass or fail.

## Interface
Parameters:
- `W`, 16: response and signature width in bits (W ≥ 2).
- `POLY`, 16'h002D: Galois feedback taps (W bits; bit i set = XOR into bit i).
- `SEED`, 0: signature value loaded on `start`.
- `NUM_PATTERNS`, 256: number of responses to compact per run (≥ 1).
- `GOLDEN`, 0: expected final signature.
- `TIMEOUT`, 1024: idle-cycle limit for the watchdog (used only with `MISR_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a run; sampled in IDLE or DONE.
- `resp_valid`, in, 1: `resp` holds a valid response this cycle.
- `resp`, in, W: circuit-under-test response word.
- `busy`, out, 1: high in RUN or CHECK.
- `done`, out, 1: run finished; held until the next `start`.
- `pass`, out, 1: final signature equals `GOLDEN`; meaningful only while `done` = 1.
- `timeout`, out, 1: run aborted by the watchdog.
- `signature`, out, W: current MISR contents.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- **Reset (`reset_n` = 0, any time, including mid-run):** state = IDLE; `signature` = SEED; pattern count = 0; `busy` = `done` = `pass` = `timeout` = 0.
- **IDLE or DONE with `start` = 1:**
  - Load `signature` = SEED and count = 0.
  - Clear `done`, `pass` and `timeout`.
  - Go to RUN.
- **RUN with `resp_valid` = 1:**
  - Update: sig_next = ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ resp.
  - Increment count.
  - If count == NUM_PATTERNS-1 before the increment, go to CHECK.
- **RUN with `resp_valid` = 0:** hold `signature` and count.
- **CHECK (one cycle):** `pass` <= (signature == GOLDEN); `done` <= 1; go to DONE.
- **DONE:** `signature`, `pass` and `done` are stable until `start` or reset.
- `start` is ignored in RUN and CHECK.
- `resp_valid` is ignored outside RUN, including the CHECK cycle.
- Count width is clog2(NUM_PATTERNS+1) bits. The count never wraps because the run ends exactly at NUM_PATTERNS.
- All arithmetic is modulo 2 per bit. No carries.

## Timing
- Compaction has 1-cycle latency: a response sampled at edge k is visible on `signature` after edge k.
- `busy` rises at the edge that samples `start`.
- Let edge t sample the final response. Then:
  - The FSM is in CHECK during the following cycle.
  - `done` and `pass` rise at edge t+1.
  - `busy` falls at edge t+1.
- Back-to-back runs: `start` sampled in DONE restarts on that edge, so `done` drops in the same cycle `busy` rises.
- NUM_PATTERNS = 1: the first valid response leads to CHECK immediately.

## Configuration
- Macro: `MISR_TIMEOUT_EN`.
- **Defined:**
  - An idle counter clears on every valid response in RUN and increments on every RUN cycle with `resp_valid` = 0.
  - When it reaches TIMEOUT, the FSM goes to DONE with `timeout` = 1, `pass` = 0 and `done` = 1.
  - `signature` holds its last value.
  - A valid response in the same cycle the limit is reached takes priority and is compacted; no timeout fires that cycle.
- **Undefined:** no idle counter; `timeout` is tied to 0; RUN waits indefinitely.

## Test plan
All scenarios use W=4, POLY=4'b0011, SEED=0 unless noted.
- **Basic pass:** NUM_PATTERNS=3, GOLDEN=4'h3; `start`, then responses 1, 2, 3 on consecutive cycles → signature 1, 0, 3; `done` = 1 and `pass` = 1 one edge after the last sample; `busy` = 0.
- **Feedback and fail:** NUM_PATTERNS=2, GOLDEN=4'h3; responses 8, 8 → signature 8, then B; `done` = 1, `pass` = 0.
- **Gaps and ignored start:** NUM_PATTERNS=3, GOLDEN=4'h3; responses 1, 2, 3 with 2 idle cycles between each, and `start` pulsed mid-run → same signature 3, `pass` = 1; the run is not restarted.
- **Reset mid-run:** pull `reset_n` low after response 2 → `signature` = 0 and all outputs 0 asynchronously; a fresh run then passes with the basic-pass values.
- **Restart from DONE:** `start` while `done` = 1 → `done` and `pass` clear and `signature` = SEED at that edge; a second run with responses 8, 8 ends with signature B.
- **Watchdog (`MISR_TIMEOUT_EN`, TIMEOUT=5):** one response, then `resp_valid` held low → after 5 idle cycles `done` = 1, `timeout` = 1, `pass` = 0, `signature` = 1.
